// File: rtl/reward_tx_framer.sv
// Queues reward packets, waits out a CSMA DIFS plus random backoff, then streams each packet as a fixed frame.
// Define REWARD_TX_CRC_EN to append a CRC-16/CCITT word (9-word frame instead of 8).
module reward_tx_framer #(
  parameter int WORD_WIDTH  = 16,
  parameter int QDEPTH      = 2,
  parameter int DIFS_CYCLES = 8,
  parameter int BO_BITS     = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      reward_done,
  input  logic [2:0]                rPacketType,
  input  logic [WORD_WIDTH-1:0]     rDestinationID,
  input  logic [WORD_WIDTH-1:0]     rSourceID,
  input  logic [WORD_WIDTH-1:0]     rSourceHops,
  input  logic [WORD_WIDTH-1:0]     rEnergyLeft,
  input  logic [WORD_WIDTH-1:0]     rQValue,
  input  logic [WORD_WIDTH-1:0]     rChosenCH,
  input  logic [WORD_WIDTH-1:0]     rHopsFromCH,
  input  logic [WORD_WIDTH-1:0]     myNodeID,
  input  logic                      channel_busy,
  input  logic                      tx_ready,
  output logic [WORD_WIDTH-1:0]     tx_data,
  output logic                      tx_valid,
  output logic                      tx_last,
  output logic                      tx_busy,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      drop_pulse,
  output logic [7:0]                drop_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DIFS_CYCLES) + 1;
  localparam int BW = BO_BITS + 1;
`ifdef REWARD_TX_CRC_EN
  localparam int NWORDS = 9;
`else
  localparam int NWORDS = 8;
`endif
  localparam logic [3:0]    LAST_IDX  = 4'(NWORDS - 1);
  localparam logic [4:0]    FRAME_LEN = 5'(NWORDS);
  localparam logic [DW-1:0] DIFS_LAST = DW'(DIFS_CYCLES - 1);
  localparam logic [BW-1:0] BO_ONE    = BW'(1);
  localparam logic [CW-1:0] Q_FULL    = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, SENSE, BACKOFF, SEND} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                  state, state_nx;
  logic                    done_q;
  logic [15:0]             lfsr;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic [2:0]              mem_type [QDEPTH];
  logic [7*WORD_WIDTH-1:0] mem_body [QDEPTH];
  logic [2:0]              head_type;
  logic [7*WORD_WIDTH-1:0] head_body;
  logic [DW-1:0]           idle_cnt, idle_nx, busy_cnt, busy_nx;
  logic [BW-1:0]           bo_cnt, bo_nx, bo_seed;
  logic                    bo_held, held_nx;
  logic [3:0]              widx, widx_nx;
  logic                    cap, full, hs, last_word, pop, push, drop;
  logic                    unused_id;

  assign head_type = mem_type[rd_ptr];
  assign head_body = mem_body[rd_ptr];
  assign full      = (count == Q_FULL);
  assign cap       = en && reward_done && !done_q &&
                     (rPacketType != 3'b001) && (rPacketType != 3'b111);
  assign hs        = tx_valid && tx_ready;
  assign last_word = (widx == LAST_IDX);
  assign pop       = hs && last_word;
  // A full queue still accepts a capture when the head is leaving in the same cycle.
  assign push      = cap && (!full || pop);
  assign drop      = cap && full && !pop;
  assign bo_seed   = {1'b0, lfsr[BO_BITS-1:0] ^ myNodeID[BO_BITS-1:0]} + BO_ONE;
  assign unused_id = ^myNodeID[WORD_WIDTH-1:BO_BITS];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_q     <= 1'b0;
      lfsr       <= 16'hACE1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      done_q     <= reward_done;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count + CW'(push) - CW'(pop);
      drop_pulse <= drop;
      if (drop) drop_count <= sat_inc8(drop_count);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_type[wr_ptr] <= rPacketType;
      mem_body[wr_ptr] <= {rHopsFromCH, rChosenCH, rQValue, rEnergyLeft,
                           rSourceHops, rSourceID, rDestinationID};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      idle_cnt <= '0;
      busy_cnt <= '0;
      bo_cnt   <= '0;
      bo_held  <= 1'b0;
      widx     <= '0;
    end else begin
      state    <= state_nx;
      idle_cnt <= idle_nx;
      busy_cnt <= busy_nx;
      bo_cnt   <= bo_nx;
      bo_held  <= held_nx;
      widx     <= widx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idle_nx  = idle_cnt;
    busy_nx  = busy_cnt;
    bo_nx    = bo_cnt;
    held_nx  = bo_held;
    widx_nx  = widx;
    case (state)
      IDLE: begin
        idle_nx = '0;
        busy_nx = '0;
        held_nx = 1'b0;
        widx_nx = '0;
        if (count != '0) state_nx = SENSE;
      end
      SENSE: begin
        if (channel_busy) begin
          idle_nx = '0;
        end else if (idle_cnt == DIFS_LAST) begin
          idle_nx  = '0;
          busy_nx  = '0;
          state_nx = BACKOFF;
          // A backoff interrupted by a long busy period resumes where it stopped.
          if (!bo_held) bo_nx = bo_seed;
        end else begin
          idle_nx = idle_cnt + 1'b1;
        end
      end
      BACKOFF: begin
        if (channel_busy) begin
          if (busy_cnt == DIFS_LAST) begin
            busy_nx  = '0;
            idle_nx  = '0;
            held_nx  = 1'b1;
            state_nx = SENSE;
          end else begin
            busy_nx = busy_cnt + 1'b1;
          end
        end else begin
          busy_nx = '0;
          if (bo_cnt <= BO_ONE) begin
            bo_nx    = '0;
            widx_nx  = '0;
            state_nx = SEND;
          end else begin
            bo_nx = bo_cnt - BO_ONE;
          end
        end
      end
      SEND: begin
        if (hs) begin
          if (last_word) state_nx = IDLE;
          else           widx_nx  = widx + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef REWARD_TX_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_word(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    c = c_in;
    for (int b = 15; b >= 0; b--) begin
      if (c[15] ^ d[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  crc <= 16'hFFFF;
    else if (state == IDLE)     crc <= 16'hFFFF;
    else if (hs && !last_word)  crc <= crc16_word(crc, tx_data[15:0]);
  end
`endif

  always_comb begin
    tx_data = '0;
    if (state == SEND) begin
      case (widx)
        4'd0: tx_data = WORD_WIDTH'({head_type, FRAME_LEN, 8'hA5});
        4'd1: tx_data = head_body[0*WORD_WIDTH +: WORD_WIDTH];
        4'd2: tx_data = head_body[1*WORD_WIDTH +: WORD_WIDTH];
        4'd3: tx_data = head_body[2*WORD_WIDTH +: WORD_WIDTH];
        4'd4: tx_data = head_body[3*WORD_WIDTH +: WORD_WIDTH];
        4'd5: tx_data = head_body[4*WORD_WIDTH +: WORD_WIDTH];
        4'd6: tx_data = head_body[5*WORD_WIDTH +: WORD_WIDTH];
        4'd7: tx_data = head_body[6*WORD_WIDTH +: WORD_WIDTH];
`ifdef REWARD_TX_CRC_EN
        4'd8: tx_data = WORD_WIDTH'(crc);
`endif
        default: tx_data = '0;
      endcase
    end
  end

  assign tx_valid = (state == SEND);
  assign tx_last  = tx_valid && last_word;
  assign tx_busy  = (state != IDLE);
  assign q_count  = count;

endmodule
